// File: rtl/fifo_byte_packer.sv
`default_nettype none
// ============================================================================
// Module  : fifo_byte_packer
// Purpose : Pops WIDTH-bit entries from a 1-cycle-latency FIFO, packs PACK of
//           them per word onto a valid/ready stream; flush emits a partial
//           word with a lane-keep mask. FIFO_BYTE_PACKER_STATS_EN adds
//           word/flush counters.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_byte_packer #(
    parameter int WIDTH = 8,
    parameter int PACK  = 4,
    parameter int CNT_W = $clog2(PACK + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic [WIDTH-1:0]        fifo_dout,
    input  logic                    flush,
    output logic [WIDTH*PACK-1:0]   out_data,
    output logic [PACK-1:0]         out_keep,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
`ifdef FIFO_BYTE_PACKER_STATS_EN
    ,
    output logic [15:0]             word_cnt,
    output logic [15:0]             flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_FULL  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_PACK     = CNT_W'(PACK);
    localparam logic [CNT_W:0]   C_PACK_EXT = (CNT_W + 1)'(PACK);

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        acc_q [PACK];
    logic [WIDTH-1:0]        acc_d [PACK];
    logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
    logic                    inflight_q, inflight_d;
    logic                    flush_pend_q, flush_pend_d;
    logic [WIDTH*PACK-1:0]   out_data_q, out_data_d;
    logic [PACK-1:0]         out_keep_q, out_keep_d;
    logic                    out_valid_q, out_valid_d;

    logic [CNT_W:0]          w_fill;
    logic                    w_full;
    logic                    w_has_data;
    logic                    w_xfer;
    logic [PACK-1:0]         w_keep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            acc_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_valid_q  <= 1'b0;
            for (int i = 0; i < PACK; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            inflight_q   <= inflight_d;
            flush_pend_q <= flush_pend_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_valid_q  <= out_valid_d;
            for (int i = 0; i < PACK; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_cnt_d    = acc_cnt_q;
        flush_pend_d = flush_pend_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_valid_d  = out_valid_q;
        w_keep       = '0;
        for (int i = 0; i < PACK; i++) begin
            acc_d[i] = acc_q[i];
        end

        // Count the in-flight byte so we never pop beyond the lanes available.
        w_fill     = {1'b0, acc_cnt_q} + {{CNT_W{1'b0}}, inflight_q};
        fifo_rd_en = !rst && !fifo_empty && !flush_pend_q && (w_fill < C_PACK_EXT);
        inflight_d = fifo_rd_en;

        w_full     = (acc_cnt_q == C_PACK);
        w_has_data = (acc_cnt_q != '0) || inflight_q;
        w_xfer     = (w_full || (flush_pend_q && !inflight_q && (acc_cnt_q != '0)))
                     && (!out_valid_q || out_ready);

        for (int i = 0; i < PACK; i++) begin
            w_keep[i] = (CNT_W'(i) < acc_cnt_q);
        end

        if (w_xfer) begin
            out_valid_d = 1'b1;
            out_keep_d  = w_keep;
            for (int i = 0; i < PACK; i++) begin
                out_data_d[i*WIDTH +: WIDTH] = w_keep[i] ? acc_q[i] : '0;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (w_xfer) begin
            acc_cnt_d = inflight_q ? CNT_W'(1) : '0;
            if (inflight_q) begin
                acc_d[0] = fifo_dout;
            end
        end else if (inflight_q) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
            for (int i = 0; i < PACK; i++) begin
                if (CNT_W'(i) == acc_cnt_q) begin
                    acc_d[i] = fifo_dout;
                end
            end
        end

        // A flush that coincides with a transfer emptying the accumulator has
        // nothing left to emit, so it must not arm a pending flush.
        if (w_xfer) begin
            flush_pend_d = 1'b0;
        end
        if (flush && !flush_pend_q && w_has_data && !(w_xfer && !inflight_q)) begin
            flush_pend_d = 1'b1;
        end

        if (flush_pend_d) begin
            state_d = S_FLUSH;
        end else if (acc_cnt_d == C_PACK) begin
            state_d = S_FULL;
        end else if ((acc_cnt_d != '0) || inflight_d) begin
            state_d = S_FILL;
        end else begin
            state_d = S_IDLE;
        end
    end

    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);

`ifdef FIFO_BYTE_PACKER_STATS_EN
    logic [15:0] word_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else if (out_valid_q && out_ready) begin
            if (word_cnt_q != 16'hFFFF) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
            if ((out_keep_q != {PACK{1'b1}}) && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign word_cnt  = word_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_byte_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_byte_packer
// Purpose : Directed, table-driven bench for fifo_byte_packer with a
//           1-cycle-latency FIFO model and an output-stream monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_byte_packer;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout;
    logic        flush;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
`ifdef FIFO_BYTE_PACKER_STATS_EN
    logic [15:0] word_cnt;
    logic [15:0] flush_cnt;
`endif

    fifo_byte_packer #(.WIDTH(8), .PACK(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .flush      (flush),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
`ifdef FIFO_BYTE_PACKER_STATS_EN
        ,
        .word_cnt   (word_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: bench writes mem/wr_ptr, the model owns rd_ptr.
    logic [7:0] mem [256];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       underflow = 1'b0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= wr_ptr;
            fifo_dout <= 8'h00;
        end else if (fifo_rd_en) begin
            if (rd_ptr == wr_ptr) begin
                underflow <= 1'b1;
            end else begin
                fifo_dout <= mem[rd_ptr % 256];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    // Output monitor, sampled mid-cycle.
    logic [31:0] mon_data [$];
    logic [3:0]  mon_keep [$];
    int          mon_cyc  [$];
    int          cyc = 0;
    int          pops = 0;
    int          vcyc = 0;
    int          hold_viol = 0;
    int          tot_words = 0;
    int          tot_part = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    logic [3:0]  prev_keep = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            tot_words = 0;
            tot_part  = 0;
            prev_hold = 1'b0;
        end else begin
            if (fifo_rd_en) pops = pops + 1;
            if (out_valid) vcyc = vcyc + 1;
            if (prev_hold && (!out_valid || out_data !== prev_data || out_keep !== prev_keep))
                hold_viol = hold_viol + 1;
            if (out_valid && out_ready) begin
                mon_data.push_back(out_data);
                mon_keep.push_back(out_keep);
                mon_cyc.push_back(cyc);
                tot_words = tot_words + 1;
                if (out_keep != 4'hF) tot_part = tot_part + 1;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_keep = out_keep;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 256] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    typedef struct packed {
        logic [3:0]  n;
        logic [63:0] bytes;
        logic        flush_en;
        logic [3:0]  flush_at;
        logic [1:0]  exp_words;
        logic [63:0] exp_w;
        logic [7:0]  exp_k;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v, input int idx);
        int m0;
        int p0;
        int v0;
        int nw;
        m0 = mon_data.size();
        p0 = pops;
        v0 = vcyc;
        for (int i = 0; i < int'(v.n); i++) push(v.bytes[i*8 +: 8]);
        if (v.flush_en) begin
            repeat (int'(v.flush_at)) tick();
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
        repeat (30) tick();
        nw = mon_data.size() - m0;
        check($sformatf("v%0d words", idx), nw, 32'(v.exp_words));
        for (int j = 0; j < int'(v.exp_words); j++) begin
            if (m0 + j < mon_data.size()) begin
                check($sformatf("v%0d data%0d", idx, j), mon_data[m0+j], v.exp_w[j*32 +: 32]);
                check($sformatf("v%0d keep%0d", idx, j), 32'(mon_keep[m0+j]), 32'(v.exp_k[j*4 +: 4]));
            end
        end
        check($sformatf("v%0d pops", idx), pops - p0, 32'(v.n));
        check($sformatf("v%0d valid_cycles", idx), vcyc - v0, 32'(v.exp_words));
        check($sformatf("v%0d busy_end", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        int   m0;
        int   p0;
        int   v0;
        int   h0;
        logic busy_seen;

        //          n   bytes                   fl  at  nw  words                   keeps
        vecs[0] = '{4'd4, 64'h44332211,          1'b0, 4'd0, 2'd1, 64'h44332211,          8'h0F};
        vecs[1] = '{4'd2, 64'hBBAA,              1'b1, 4'd2, 2'd1, 64'h0000BBAA,          8'h03};
        vecs[2] = '{4'd0, 64'h0,                 1'b1, 4'd0, 2'd0, 64'h0,                 8'h00};
        vecs[3] = '{4'd5, 64'h0504030201,        1'b1, 4'd8, 2'd2, 64'h00000005_04030201, 8'h1F};
        vecs[4] = '{4'd4, 64'hA4A3A2A1,          1'b1, 4'd4, 2'd1, 64'hA4A3A2A1,          8'h0F};
        vecs[5] = '{4'd8, 64'h0706050403020100,  1'b0, 4'd0, 2'd2, 64'h07060504_03020100, 8'hFF};
        vecs[6] = '{4'd2, 64'h2010,              1'b1, 4'd1, 2'd1, 64'h00002010,          8'h03};

        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst out_keep", 32'(out_keep), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst rd_en", 32'(fifo_rd_en), 32'd0);
        rst = 1'b0;
        tick();

        // FIFO empty throughout.
        busy_seen = 1'b0;
        p0 = pops;
        m0 = mon_data.size();
        repeat (20) begin
            tick();
            if (busy || out_valid) busy_seen = 1'b1;
        end
        check("empty pops", pops - p0, 32'd0);
        check("empty words", mon_data.size() - m0, 32'd0);
        check("empty busy_or_valid", 32'(busy_seen), 32'd0);

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // Backpressure: 8 bytes, output stalled.
        out_ready = 1'b0;
        p0 = pops;
        m0 = mon_data.size();
        h0 = hold_viol;
        for (int i = 0; i < 8; i++) push(8'(i));
        repeat (14) tick();
        check("bp pops", pops - p0, 32'd8);
        check("bp out_valid", 32'(out_valid), 32'd1);
        check("bp held_data", out_data, 32'h03020100);
        check("bp held_keep", 32'(out_keep), 32'hF);
        check("bp busy", 32'(busy), 32'd1);
        check("bp hold_stable", hold_viol - h0, 32'd0);
        out_ready = 1'b1;
        repeat (10) tick();
        check("bp words", mon_data.size() - m0, 32'd2);
        if (mon_data.size() - m0 == 2) begin
            check("bp word0", mon_data[m0], 32'h03020100);
            check("bp word1", mon_data[m0+1], 32'h07060504);
            check("bp consecutive", mon_cyc[m0+1] - mon_cyc[m0], 32'd1);
        end
        check("bp pops_final", pops - p0, 32'd8);

        // Reset mid-word discards partial data.
        push(8'hE1); push(8'hE2); push(8'hE3);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        push(8'h99);
        #1;
        check("midrst rd_en", 32'(fifo_rd_en), 32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        m0 = mon_data.size();
        for (int i = 1; i <= 4; i++) push(8'(i));
        repeat (15) tick();
        check("midrst words", mon_data.size() - m0, 32'd1);
        if (mon_data.size() - m0 == 1) check("midrst word", mon_data[m0], 32'h04030201);

        // Two more full words then a one-byte flush.
        m0 = mon_data.size();
        for (int i = 0; i < 9; i++) push(8'h21 + 8'(i));
        repeat (20) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (15) tick();
        check("stat words", mon_data.size() - m0, 32'd3);
        if (mon_data.size() - m0 == 3) begin
            check("stat w0", mon_data[m0], 32'h24232221);
            check("stat w1", mon_data[m0+1], 32'h28272625);
            check("stat w2", mon_data[m0+2], 32'h00000029);
            check("stat k2", 32'(mon_keep[m0+2]), 32'h1);
        end
`ifdef FIFO_BYTE_PACKER_STATS_EN
        check("word_cnt", 32'(word_cnt), 32'd4);
        check("flush_cnt", 32'(flush_cnt), 32'd1);
        check("word_cnt_model", 32'(word_cnt), 32'(tot_words));
        check("flush_cnt_model", 32'(flush_cnt), 32'(tot_part));
`endif

        check("no_underflow", 32'(underflow), 32'd0);
        check("hold_total", hold_viol, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
